// File: rtl/fir_decim_mc.sv
// Multi-channel decimating FIR: one selected lane per input beat, one multiplier
// time-shared across all taps, rounded and saturated result per decimation period.
module fir_decim_mc #(
    parameter int unsigned TAP_COUNT  = 120,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned DECIM      = 8,
    parameter int unsigned CHANNELS   = 16,
    parameter int unsigned ACC_WIDTH  = 48,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned SHIFT      = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           s_tvalid,
    output logic                           s_tready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_tdata,
    input  logic [$clog2(CHANNELS)-1:0]    ch_sel,
    input  logic                           coef_we,
    input  logic [$clog2(TAP_COUNT)-1:0]   coef_addr,
    input  logic [COEF_WIDTH-1:0]          coef_wdata,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [OUT_WIDTH-1:0]           m_tdata,
    output logic                           ovf
);

    localparam int unsigned CH_W   = $clog2(CHANNELS);
    localparam int unsigned TAP_W  = $clog2(TAP_COUNT);
    localparam int unsigned CNT_W  = $clog2(DECIM + 1);
    localparam int unsigned PROD_W = DATA_WIDTH + COEF_WIDTH;

    localparam logic signed [ACC_WIDTH:0] ONE     = {{ACC_WIDTH{1'b0}}, 1'b1};
    localparam logic signed [ACC_WIDTH:0] HALF    = ONE <<< (SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MAX = (ONE <<< (OUT_WIDTH - 1)) - ONE;
    localparam logic signed [ACC_WIDTH:0] OUT_MIN = -OUT_MAX - ONE;

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                       state_q, state_d;
    logic signed [COEF_WIDTH-1:0] coeff   [TAP_COUNT];
    logic signed [DATA_WIDTH-1:0] samples [TAP_COUNT];
    logic [CH_W-1:0]              prev_ch_q;
    logic [CNT_W-1:0]             cnt_q, cnt_next;
    logic [TAP_W-1:0]             tap_q;
    logic signed [ACC_WIDTH-1:0]  acc_q;

    logic                         accept, ch_switch, period_done, last_tap;
    logic signed [DATA_WIDTH-1:0] new_sample;
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_WIDTH:0]    rounded, scaled;
    logic signed [OUT_WIDTH-1:0]  sat_val;
    logic                         sat_hit;

    assign accept      = s_tvalid && s_tready;
    assign new_sample  = s_tdata[ch_sel*DATA_WIDTH +: DATA_WIDTH];
    assign ch_switch   = ch_sel != prev_ch_q;
    // A lane change starts a fresh decimation period with this sample as its first.
    assign cnt_next    = ch_switch ? CNT_W'(1) : cnt_q + CNT_W'(1);
    assign period_done = cnt_next == CNT_W'(DECIM);
    assign last_tap    = tap_q == TAP_W'(TAP_COUNT - 1);
    assign prod        = samples[tap_q] * coeff[tap_q];

    always_comb begin
        rounded = {acc_q[ACC_WIDTH-1], acc_q} + HALF;
        scaled  = rounded >>> SHIFT;
        sat_hit = 1'b1;
        if (scaled > OUT_MAX) begin
            sat_val = OUT_MAX[OUT_WIDTH-1:0];
        end else if (scaled < OUT_MIN) begin
            sat_val = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            sat_val = scaled[OUT_WIDTH-1:0];
            sat_hit = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && period_done) state_d = StMac;
            StMac:   if (last_tap) state_d = StOut;
            StOut:   if (m_tvalid && m_tready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            s_tready  <= 1'b0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            ovf       <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            tap_q     <= '0;
            prev_ch_q <= '0;
            for (int i = 0; i < TAP_COUNT; i++) samples[i] <= '0;
        end else begin
            state_q  <= state_d;
            s_tready <= (state_d == StIdle);
            if (accept) begin
                prev_ch_q  <= ch_sel;
                cnt_q      <= period_done ? '0 : cnt_next;
                samples[0] <= new_sample;
                for (int i = 1; i < TAP_COUNT; i++) begin
                    samples[i] <= ch_switch ? '0 : samples[i-1];
                end
                if (period_done) acc_q <= '0;
            end
            if (state_q == StMac) begin
                acc_q <= acc_q + ACC_WIDTH'(prod);
                tap_q <= last_tap ? '0 : tap_q + TAP_W'(1);
            end
            // First OUT cycle registers the result; later cycles wait for the handshake.
            if (state_q == StOut) begin
                if (!m_tvalid) begin
                    m_tvalid <= 1'b1;
                    m_tdata  <= sat_val;
                    if (sat_hit) ovf <= 1'b1;
                end else if (m_tready) begin
                    m_tvalid <= 1'b0;
                end
            end
        end
    end

    // Coefficients survive reset; writes land only while idle and in range.
    always_ff @(posedge clk) begin
        if (coef_we && state_q == StIdle && 32'(coef_addr) < TAP_COUNT) begin
            coeff[coef_addr] <= coef_wdata;
        end
    end

endmodule

// File: tb/tb_fir_decim_mc.sv
// Scoreboard bench: two instances (32-bit and 16-bit output) share stimulus; a
// behavioural model pushes expected outputs, a negedge monitor pops and compares.
module tb_fir_decim_mc;

    localparam int T  = 120;
    localparam int D  = 8;
    localparam int CH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_tvalid = 1'b0;
    logic [CH*16-1:0] s_tdata = '0;
    logic [3:0]    ch_sel = '0;
    logic          coef_we = 1'b0;
    logic [6:0]    coef_addr = '0;
    logic [15:0]   coef_wdata = '0;
    logic          rand_ready = 1'b0, rr = 1'b1, mtr = 1'b1;
    logic          m_tready;
    logic          s_tready, m_tvalid, ovf;
    logic [31:0]   m_tdata;
    logic          s_tready16, m_tvalid16, ovf16;
    logic [15:0]   m_tdata16;

    assign m_tready = rand_ready ? rr : mtr;

    always #5 clk = ~clk;

    fir_decim_mc dut (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .ch_sel(ch_sel), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .ovf(ovf)
    );

    fir_decim_mc #(.OUT_WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready16), .s_tdata(s_tdata),
        .ch_sel(ch_sel), .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .m_tvalid(m_tvalid16), .m_tready(m_tready), .m_tdata(m_tdata16), .ovf(ovf16)
    );

    typedef struct {
        longint v32;
        longint v16;
        bit     s32;
        bit     s16;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0, errors = 0;
    longint coef_m[T];
    longint hist[$];
    int     cnt_m = 0, prev_m = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: history of the current lane, newest first; dot product every D-th sample.
    function automatic void model_accept(input logic [15:0] v, input int ch);
        longint y = 0;
        longint r;
        exp_t   e;
        if (ch != prev_m) begin
            hist.delete();
            cnt_m = 0;
        end
        prev_m = ch;
        hist.push_front(longint'($signed(v)));
        if (hist.size() > T) void'(hist.pop_back());
        cnt_m++;
        if (cnt_m == D) begin
            cnt_m = 0;
            foreach (hist[k]) y += hist[k] * coef_m[k];
            r = (y + 64'sd16384) >>> 15;
            e.s32 = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            e.v32 = (r > 64'sd2147483647) ? 64'sd2147483647 :
                    (r < -64'sd2147483648) ? -64'sd2147483648 : r;
            e.s16 = (r > 64'sd32767) || (r < -64'sd32768);
            e.v16 = (r > 64'sd32767) ? 64'sd32767 : (r < -64'sd32768) ? -64'sd32768 : r;
            sb.push_back(e);
        end
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] v, input int ch, input bit cw = 1'b0,
                        input int ca = 0, input logic [15:0] cd = '0);
        int guard = 0;
        for (int k = 0; k < CH; k++) s_tdata[k*16 +: 16] = 16'($urandom);
        s_tdata[ch*16 +: 16] = v;
        ch_sel   = 4'(ch);
        s_tvalid = 1'b1;
        while (!s_tready && guard < 3000) begin
            tick();
            guard++;
        end
        if (!s_tready) begin
            check("send_timeout", s_tready, 1);
            s_tvalid = 1'b0;
            return;
        end
        coef_we    = cw;
        coef_addr  = 7'(ca);
        coef_wdata = cd;
        if (cw && ca < T) coef_m[ca] = longint'($signed(cd));
        model_accept(v, ch);
        tick();
        s_tvalid = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic write_coefs(input int mode);
        for (int k = 0; k < T; k++) begin
            logic [15:0] c;
            case (mode)
                0:       c = (k == 0) ? 16'h4000 : 16'h0000;
                1:       c = 16'(k);
                2:       c = 16'($urandom);
                default: c = 16'h7fff;
            endcase
            coef_we    = 1'b1;
            coef_addr  = 7'(k);
            coef_wdata = c;
            coef_m[k]  = longint'($signed(c));
            tick();
        end
        coef_we    = 1'b1;
        coef_addr  = 7'd125;
        coef_wdata = 16'h1234;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !s_tready) && n < 5000) begin
            tick();
            n++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!m_tvalid && n < 400) begin
            tick();
            n++;
        end
    endtask

    // Monitor: compares every transfer against the scoreboard and checks hold while stalled.
    logic [31:0] last32;
    logic [15:0] last16;
    bit          stalled = 1'b0;
    bit          ovf32_m = 1'b0, ovf16_m = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            ovf32_m = 1'b0;
            ovf16_m = 1'b0;
            stalled = 1'b0;
        end else begin
            if (m_tvalid16 != m_tvalid) check("valid_lockstep", m_tvalid16, m_tvalid);
            if (stalled) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_data32", m_tdata, last32);
                check("hold_data16", m_tdata16, last16);
            end
            if (m_tvalid && sb.size() == 0) begin
                check("unexpected_output", sb.size(), 1);
            end else if (m_tvalid && m_tready) begin
                e = sb.pop_front();
                ovf32_m = ovf32_m | e.s32;
                ovf16_m = ovf16_m | e.s16;
                check("data32", longint'($signed(m_tdata)), e.v32);
                check("data16", longint'($signed(m_tdata16)), e.v16);
                check("ovf32", ovf, longint'(ovf32_m));
                check("ovf16", ovf16, longint'(ovf16_m));
            end
            stalled = m_tvalid && !m_tready;
            last32  = m_tdata;
            last16  = m_tdata16;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tick(3);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();
        check("ready_after_rst", s_tready, 1);

        // Single tap, latency and exact value
        write_coefs(0);
        for (int i = 0; i < D; i++) send(16'h2000, 0);
        wait_valid(n);
        check("latency", n, 121);
        check("single_tap_value", m_tdata, 32'h0000_1000);
        drain();

        // Impulse response on a new lane
        write_coefs(1);
        send(16'h4000, 1);
        for (int i = 1; i < 16 * D; i++) send(16'h0000, 1);
        drain();

        // Backpressure
        mtr = 1'b0;
        for (int i = 0; i < D; i++) send(16'($urandom), 1);
        wait_valid(n);
        check("bp_valid_seen", m_tvalid, 1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_s_tready", s_tready, 0);
        end
        mtr = 1'b1;
        tick();
        check("bp_valid_drop", m_tvalid, 0);
        check("bp_ready_back", s_tready, 1);
        drain();

        // Channel switch, same-cycle coefficient write, writes while busy ignored
        write_coefs(2);
        for (int i = 0; i < 5; i++) send(16'($urandom), 3);
        for (int i = 0; i < D - 1; i++) send(16'($urandom), 5);
        send(16'($urandom), 5, 1'b1, 0, 16'($urandom));
        tick(2);
        coef_we    = 1'b1;
        coef_addr  = 7'd1;
        coef_wdata = 16'($urandom);
        tick();
        coef_we = 1'b0;
        drain();
        for (int i = 0; i < D; i++) send(16'($urandom), 5);
        drain();

        // Saturation on the 16-bit instance
        write_coefs(3);
        for (int i = 0; i < T; i++) send(16'h7fff, 2);
        drain();
        check("sat_pos_value16", m_tdata16, 16'h7fff);
        for (int i = 0; i < T; i++) send(16'h8000, 2);
        drain();
        check("sat_neg_value16", m_tdata16, 16'h8000);
        check("sat_ovf16", ovf16, 1);
        check("sat_ovf32_clear", ovf, 0);

        // Randomised traffic with random output readiness
        write_coefs(2);
        rand_ready = 1'b1;
        begin
            int ch = 6;
            for (int i = 0; i < 64; i++) begin
                if ($urandom_range(0, 11) == 0) ch = (ch == 6) ? 7 : 6;
                send(16'($urandom), ch);
            end
        end
        drain();
        rand_ready = 1'b0;

        // Reset ten cycles into MAC aborts the result
        for (int i = 0; i < D; i++) send(16'($urandom), 4);
        tick(10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hist.delete();
        cnt_m  = 0;
        prev_m = 0;
        check("midmac_ovf", ovf, 0);
        check("midmac_ovf16", ovf16, 0);
        tick();
        check("midmac_ready", s_tready, 1);
        for (int i = 0; i < D - 1; i++) send(16'($urandom), 0);
        tick(200);
        check("midmac_no_early_output", m_tvalid, 0);
        send(16'($urandom), 0);
        wait_valid(n);
        check("midmac_new_period_latency", n, 121);
        drain();

        tick(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
